// File: rtl/hdsiso_mux_scan.sv
// Registered N:1 word multiplexer with static, auto-scan, one-shot sweep and freeze modes.
// Feeds the serialiser shift stage; dout_ch/dout_stb tag which channel each word came from.
module hdsiso_mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int DWELL_W  = 4,
  localparam int CW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CW-1:0]             sel_in,
  input  logic [1:0]                mode,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      start,
  output logic [WIDTH-1:0]          dout,
  output logic [CW-1:0]             dout_ch,
  output logic                      dout_stb,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_SWEEP  = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [CW:0]   CH_LIM  = CHANNELS[CW:0];
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  state_t               state, state_n;
  logic [CW-1:0]        ch, ch_n, ch_inc;
  logic [DWELL_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [1:0]           mode_q;
  logic                 mode_chg;
  logic                 dwell_hit;
  logic                 done_n;
  logic [WIDTH-1:0]     sel_word;

  // Word mux; ch never leaves 0..CHANNELS-1, so the '0 default is never selected.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch == CW'(k)) sel_word = din[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_n   = state;
    ch_n      = ch;
    cnt_n     = cnt;
    done_n    = 1'b0;
    mode_chg  = (mode != mode_q);
    dwell_hit = (cnt == dwell);
    ch_inc    = (ch == LAST_CH) ? '0 : ch + 1'b1;
    cnt_inc   = cnt + 1'b1;

    case (mode_t'(mode))
      MODE_STATIC: begin
        state_n = IDLE;
        cnt_n   = '0;
        if ({1'b0, sel_in} < CH_LIM) ch_n = sel_in;
      end

      MODE_SCAN: begin
        state_n = IDLE;
        if (mode_chg) begin
          cnt_n = '0;
        end else if (dwell_hit) begin
          cnt_n = '0;
          ch_n  = ch_inc;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      MODE_SWEEP: begin
        case (state)
          IDLE: begin
            cnt_n = '0;
            // A start landing on the done cycle must not retrigger the sweep.
            if (start && !done) begin
              ch_n    = '0;
              state_n = SWEEP;
            end
          end
          SWEEP: begin
            if (dwell_hit) begin
              cnt_n = '0;
              if (ch == LAST_CH) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end else begin
                ch_n = ch_inc;
              end
            end else begin
              cnt_n = cnt_inc;
            end
          end
          default: state_n = IDLE;
        endcase
      end

      MODE_FREEZE: begin
        state_n = IDLE;
        if (mode_chg) cnt_n = '0;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
      state <= state_n;
    end
  end

  // Leaving sweep mode drops state to IDLE, which clears busy without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch       <= '0;
      cnt      <= '0;
      mode_q   <= 2'b00;
      dout     <= '0;
      dout_ch  <= '0;
      dout_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ch       <= ch_n;
      cnt      <= cnt_n;
      mode_q   <= mode;
      dout     <= sel_word;
      dout_ch  <= ch;
      dout_stb <= (ch != dout_ch);
      busy     <= (state_n == SWEEP);
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_hdsiso_mux_scan.sv
// Self-checking bench for hdsiso_mux_scan: an 8-channel and a 6-channel instance share stimulus.
// Directed tables/sequences cover the corner cases; a random phase runs against a behavioural model.
module tb_hdsiso_mux_scan;

  logic        clk;
  logic        rst;
  logic [63:0] din8;
  logic [47:0] din6;
  logic [2:0]  sel_in;
  logic [1:0]  mode;
  logic [3:0]  dwell;
  logic        start;

  logic [7:0]  dout8, dout6;
  logic [2:0]  ch8, ch6;
  logic        stb8, stb6, busy8, busy6, done8, done6;

  int n_checks = 0;
  int n_err    = 0;

  assign din6 = din8[47:0];

  hdsiso_mux_scan #(.WIDTH(8), .CHANNELS(8), .DWELL_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .din(din8), .sel_in(sel_in), .mode(mode), .dwell(dwell),
    .start(start), .dout(dout8), .dout_ch(ch8), .dout_stb(stb8), .busy(busy8), .done(done8)
  );

  hdsiso_mux_scan #(.WIDTH(8), .CHANNELS(6), .DWELL_W(4)) u_dut6 (
    .clk(clk), .rst(rst), .din(din6), .sel_in(sel_in), .mode(mode), .dwell(dwell),
    .start(start), .dout(dout6), .dout_ch(ch6), .dout_stb(stb6), .busy(busy6), .done(done6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: one record of everything visible plus the dwell position.
  typedef struct {
    int ch;
    int cnt;
    int mode_q;
    int dout;
    int dout_ch;
    bit stb;
    bit busy;
    bit done;
  } mstate_t;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.ch = 0; r.cnt = 0; r.mode_q = 0; r.dout = 0; r.dout_ch = 0;
    r.stb = 0; r.busy = 0; r.done = 0;
    return r;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int nch, logic [63:0] d,
                                         int md, int sel, int dw, bit st);
    mstate_t n = s;
    bit fresh = (md != s.mode_q);
    bit scanning = (md == 1) || (md == 2 && s.busy);
    n.dout    = int'(d[s.ch*8 +: 8]);
    n.dout_ch = s.ch;
    n.stb     = (s.ch != s.dout_ch);
    n.done    = 0;
    n.mode_q  = md;
    if (md != 2) n.busy = 0;
    if (md == 0) begin
      n.cnt = 0;
      if (sel < nch) n.ch = sel;
    end else if (md == 3) begin
      if (fresh) n.cnt = 0;
    end else if (scanning) begin
      if (fresh) n.cnt = 0;
      else if (s.cnt == dw) begin
        n.cnt = 0;
        if (md == 2 && s.ch == nch - 1) begin
          n.busy = 0;
          n.done = 1;
        end else begin
          n.ch = (s.ch + 1) % nch;
        end
      end else begin
        n.cnt = (s.cnt + 1) % 16;
      end
    end else begin
      // sweep mode, idle
      n.cnt = 0;
      if (st && !s.done) begin
        n.ch   = 0;
        n.busy = 1;
      end
    end
    return n;
  endfunction

  typedef struct {
    logic [2:0] sel;
    int         exp8;
    int         exp6;
  } vec_t;

  vec_t    vecs[7];
  mstate_t m8, m6;

  initial begin : main
    int prev8, prev6, stbs8, stbs6, n_ev, last_ev, first_ev, found;
    int ev_ch[16];
    int ev_cyc[16];
    bit seen_done;

    vecs[0] = '{3'd5, 5, 5};
    vecs[1] = '{3'd7, 7, 5};
    vecs[2] = '{3'd3, 3, 3};
    vecs[3] = '{3'd6, 6, 3};
    vecs[4] = '{3'd7, 7, 3};
    vecs[5] = '{3'd0, 0, 0};
    vecs[6] = '{3'd2, 2, 2};

    for (int k = 0; k < 8; k++) din8[k*8 +: 8] = 8'h10 + 8'(k);
    rst = 1'b1; mode = 2'b00; sel_in = 3'd5; dwell = 4'd0; start = 1'b0;

    // Reset state, then static select latency
    tick(); tick();
    check("reset8", {dout8, 5'(ch8), stb8, busy8, done8}, 32'h0);
    check("reset6", {dout6, 5'(ch6), stb6, busy6, done6}, 32'h0);
    rst = 1'b0;
    tick();
    check("e1_ch8", {29'd0, ch8}, 0);
    tick();
    check("e2_dout8", dout8, 8'h15);
    check("e2_ch8", ch8, 5);
    check("e2_stb8", stb8, 1);
    tick();
    check("e3_stb8", stb8, 0);

    // Static-mode table; the 6-channel instance ignores selects 6 and 7
    prev8 = 5; prev6 = 5;
    foreach (vecs[i]) begin
      sel_in = vecs[i].sel;
      stbs8 = 0; stbs6 = 0;
      for (int c = 0; c < 2; c++) begin
        tick();
        stbs8 += int'(stb8);
        stbs6 += int'(stb6);
      end
      check($sformatf("tab%0d_ch8", i), ch8, vecs[i].exp8);
      check($sformatf("tab%0d_dout8", i), dout8, 8'h10 + vecs[i].exp8);
      check($sformatf("tab%0d_ch6", i), ch6, vecs[i].exp6);
      check($sformatf("tab%0d_dout6", i), dout6, 8'h10 + vecs[i].exp6);
      check($sformatf("tab%0d_stb8", i), stbs8, (vecs[i].exp8 != prev8) ? 1 : 0);
      check($sformatf("tab%0d_stb6", i), stbs6, (vecs[i].exp6 != prev6) ? 1 : 0);
      prev8 = vecs[i].exp8; prev6 = vecs[i].exp6;
    end

    // Auto-scan, dwell=2
    sel_in = 3'd0; tick(); tick();
    mode = 2'b01; dwell = 4'd2;
    n_ev = 0; first_ev = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (stb8 && n_ev < 16) begin
        ev_ch[n_ev] = int'(ch8);
        ev_cyc[n_ev] = c;
        n_ev++;
      end
    end
    check("scan_events", (n_ev >= 9) ? 1 : 0, 1);
    if (n_ev > 0) first_ev = ev_cyc[0];
    check("scan_first", first_ev, 5);
    for (int e = 0; e < 9 && e < n_ev; e++) begin
      check($sformatf("scan_ch%0d", e), ev_ch[e], (e + 1) % 8);
      if (e > 0) check($sformatf("scan_gap%0d", e), ev_cyc[e] - ev_cyc[e-1], 3);
    end

    // Freeze: channel holds
    mode = 2'b11;
    tick();
    last_ev = int'(ch8);
    stbs8 = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      stbs8 += int'(stb8);
    end
    check("freeze_ch", ch8, last_ev);
    check("freeze_stb", stbs8, 0);

    // Sweep, dwell=0, with starts during busy and on the done cycle
    mode = 2'b00; sel_in = 3'd0; tick(); tick();
    mode = 2'b10; dwell = 4'd0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 1 || k == 4 || k == 10);
      tick();
      start = 1'b0;
      check($sformatf("sw0_busy_k%0d", k), busy8, (k <= 8) ? 1 : 0);
      check($sformatf("sw0_done_k%0d", k), done8, (k == 9) ? 1 : 0);
      if (k >= 2) check($sformatf("sw0_dout_k%0d", k), dout8, 8'h10 + ((k - 2 > 7) ? 7 : k - 2));
      if (k <= 9) begin
        check($sformatf("sw0_busy6_k%0d", k), busy6, (k <= 6) ? 1 : 0);
        check($sformatf("sw0_done6_k%0d", k), done6, (k == 7) ? 1 : 0);
      end
    end

    // Sweep aborted by switching to static at channel 4
    mode = 2'b00; sel_in = 3'd0; tick(); tick();
    mode = 2'b10; dwell = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    found = 0; seen_done = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      tick();
      seen_done |= done8;
      if (ch8 == 3'd4) found = 1;
    end
    check("abort_reach4", found, 1);
    mode = 2'b00; sel_in = 3'd6;
    tick();
    check("abort_busy", busy8, 0);
    seen_done |= done8;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen_done |= done8;
    end
    check("abort_nodone", seen_done, 0);
    check("abort_ch", ch8, 6);
    check("abort_dout", dout8, 8'h16);

    // Asynchronous reset in the middle of a sweep
    sel_in = 3'd0; tick(); tick();
    mode = 2'b10; dwell = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst8", {dout8, 5'(ch8), stb8, busy8, done8}, 32'h0);
    check("arst6", {dout6, 5'(ch6), stb6, busy6, done6}, 32'h0);
    tick();
    #1 rst = 1'b0;
    seen_done = 0; found = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen_done |= done8;
      found |= int'(busy8);
    end
    check("arst_nobusy", found, 0);
    check("arst_nodone", seen_done, 0);
    check("arst_ch", ch8, 0);

    // Random stimulus against the behavioural model
    rst = 1'b1; mode = 2'b00; start = 1'b0;
    tick();
    rst = 1'b0;
    m8 = model_reset();
    m6 = model_reset();
    for (int c = 0; c < 1500; c++) begin
      din8   = {$urandom, $urandom};
      sel_in = 3'($urandom_range(0, 7));
      start  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0)
        dwell = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      m8 = model_step(m8, 8, din8, int'(mode), int'(sel_in), int'(dwell), start);
      m6 = model_step(m6, 6, din8, int'(mode), int'(sel_in), int'(dwell), start);
      tick();
      check($sformatf("rand8_c%0d", c), {dout8, ch8, stb8, busy8, done8},
            {8'(m8.dout), 3'(m8.dout_ch), m8.stb, m8.busy, m8.done});
      check($sformatf("rand6_c%0d", c), {dout6, ch6, stb6, busy6, done6},
            {8'(m6.dout), 3'(m6.dout_ch), m6.stb, m6.busy, m6.done});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
